// File: rtl/jsv_timer_pkg.sv
// rtl/jsv_timer_pkg.sv - register map, control bits and FSM states for the timer sequencer
package jsv_timer_pkg;

    localparam logic [3:0] REG_STATUS  = 4'd0;
    localparam logic [3:0] REG_CONTROL = 4'd1;
    localparam logic [3:0] REG_PERIODL = 4'd2;
    localparam logic [3:0] REG_SNAPL   = 4'd6;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STOP,
        ST_PERIOD,
        ST_CTRL,
        ST_CLR,
        ST_IRQ_CLR,
        ST_IRQ_GAP,
        ST_TRIG,
        ST_RD,
        ST_RD_LAST
    } state_t;

    function automatic logic [15:0] ctrl_stop_word();
        logic [15:0] w;
        w = '0;
        w[CTRL_STOP] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] ctrl_run_word(input logic cont);
        logic [15:0] w;
        w = '0;
        w[CTRL_START] = 1'b1;
        w[CTRL_ITO]   = 1'b1;
        w[CTRL_CONT]  = cont;
        return w;
    endfunction

endpackage

// File: rtl/jsv_timer_sequencer.sv
// rtl/jsv_timer_sequencer.sv - Avalon-MM master that programs, services and snapshots the interval timer
module jsv_timer_sequencer
    import jsv_timer_pkg::*;
#(
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_req,
    input  logic [63:0]       cfg_period,
    input  logic              cfg_continuous,
    output logic              cfg_ack,
    input  logic              snap_req,
    output logic              snap_ack,
    output logic [63:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic [3:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        hw_idx;
    logic [63:0]       period_q;
    logic              cont_q;
    logic [47:0]       snap_shadow;
    logic [63:0]       snap_q;
    logic [TICK_W-1:0] tick_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration happens only in IDLE; an irq raised mid-sequence waits here.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (timer_irq) begin
                    state_nxt = ST_IRQ_CLR;
                end else if (cfg_req) begin
                    state_nxt = ST_STOP;
                end else if (snap_req) begin
                    state_nxt = ST_TRIG;
                end
            end
            ST_STOP:    state_nxt = ST_PERIOD;
            ST_PERIOD:  state_nxt = (hw_idx == 2'd3) ? ST_CTRL : ST_PERIOD;
            ST_CTRL:    state_nxt = ST_CLR;
            ST_CLR:     state_nxt = ST_IDLE;
            ST_IRQ_CLR: state_nxt = ST_IRQ_GAP;
            ST_IRQ_GAP: state_nxt = ST_IDLE;
            ST_TRIG:    state_nxt = ST_RD;
            ST_RD:      state_nxt = (hw_idx == 2'd3) ? ST_RD_LAST : ST_RD;
            ST_RD_LAST: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hw_idx       <= 2'd0;
            period_q     <= '0;
            cont_q       <= 1'b0;
            snap_shadow  <= '0;
            snap_q       <= '0;
            tick_count_q <= '0;
        end else begin
            hw_idx <= (state == ST_PERIOD || state == ST_RD) ? hw_idx + 2'd1 : 2'd0;
            if (state == ST_IDLE && state_nxt == ST_STOP) begin
                period_q <= cfg_period;
                cont_q   <= cfg_continuous;
            end
            // readdata lags the address by one cycle, so RDn captures halfword n-1
            if (state == ST_RD && hw_idx != 2'd0) begin
                snap_shadow[{hw_idx - 2'd1, 4'd0} +: 16] <= avm_readdata;
            end
            if (state == ST_RD_LAST) begin
                snap_q <= {avm_readdata, snap_shadow};
            end
            if (state == ST_IRQ_CLR) begin
                tick_count_q <= tick_count_q + TICK_W'(1);
            end
        end
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = REG_STATUS;
        avm_writedata  = 16'h0000;
        cfg_ack        = 1'b0;
        snap_ack       = 1'b0;
        tick           = 1'b0;
        case (state)
            ST_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_CONTROL;
                avm_writedata  = ctrl_stop_word();
            end
            ST_PERIOD: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_PERIODL + {2'b00, hw_idx};
                avm_writedata  = period_q[{hw_idx, 4'd0} +: 16];
            end
            ST_CTRL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_CONTROL;
                avm_writedata  = ctrl_run_word(cont_q);
            end
            ST_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                cfg_ack        = 1'b1;
            end
            ST_IRQ_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                tick           = 1'b1;
            end
            ST_TRIG: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_SNAPL;
            end
            ST_RD: begin
                avm_address = REG_SNAPL + {2'b00, hw_idx};
            end
            ST_RD_LAST: begin
                snap_ack = 1'b1;
            end
            default: begin
                avm_chipselect = 1'b0;
            end
        endcase
    end

    // The last halfword is forwarded so snap_value is complete in the ack cycle.
    assign snap_value = (state == ST_RD_LAST) ? {avm_readdata, snap_shadow} : snap_q;
    assign tick_count = tick_count_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_jsv_timer_sequencer.sv
// tb/tb_jsv_timer_sequencer.sv - scoreboard bench for jsv_timer_sequencer with a behavioural timer slave
module tb_jsv_timer_sequencer;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_req = 1'b0;
    logic [63:0]   cfg_period = '0;
    logic          cfg_continuous = 1'b0;
    logic          cfg_ack;
    logic          snap_req = 1'b0;
    logic          snap_ack;
    logic [63:0]   snap_value;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          busy;
    logic [3:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [15:0]   avm_writedata;
    logic [15:0]   avm_readdata;
    logic          timer_irq;

    int n_tests = 0;
    int n_fail  = 0;

    jsv_timer_sequencer #(.TICK_W(TW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_req        (cfg_req),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_ack        (cfg_ack),
        .snap_req       (snap_req),
        .snap_ack       (snap_ack),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    // Behavioural 64-bit interval timer slave with 16-bit halfword registers
    logic [63:0] tm_period, tm_count, tm_snap;
    logic        tm_run, tm_to, tm_ito, tm_cont;
    logic [15:0] tm_rdata;
    int          to_events;
    logic [63:0] exp_snap[$];

    assign avm_readdata = tm_rdata;
    assign timer_irq    = tm_to & tm_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_period <= '0;
            tm_count  <= '0;
            tm_snap   <= '0;
            tm_run    <= 1'b0;
            tm_to     <= 1'b0;
            tm_ito    <= 1'b0;
            tm_cont   <= 1'b0;
            tm_rdata  <= '0;
            to_events <= 0;
        end else begin
            case (avm_address)
                4'd0:    tm_rdata <= {14'd0, tm_run, tm_to};
                4'd1:    tm_rdata <= {14'd0, tm_cont, tm_ito};
                4'd2:    tm_rdata <= tm_period[15:0];
                4'd3:    tm_rdata <= tm_period[31:16];
                4'd4:    tm_rdata <= tm_period[47:32];
                4'd5:    tm_rdata <= tm_period[63:48];
                4'd6:    tm_rdata <= tm_snap[15:0];
                4'd7:    tm_rdata <= tm_snap[31:16];
                4'd8:    tm_rdata <= tm_snap[47:32];
                4'd9:    tm_rdata <= tm_snap[63:48];
                default: tm_rdata <= '0;
            endcase
            if (tm_run) begin
                if (tm_count == 64'd0) begin
                    tm_to     <= 1'b1;
                    to_events <= to_events + 1;
                    tm_count  <= tm_period;
                    if (!tm_cont) tm_run <= 1'b0;
                end else begin
                    tm_count <= tm_count - 64'd1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    4'd0: if (!(tm_run && tm_count == 64'd0)) tm_to <= 1'b0;
                    4'd1: begin
                        tm_ito  <= avm_writedata[0];
                        tm_cont <= avm_writedata[1];
                        if (avm_writedata[2]) tm_run <= 1'b1;
                        if (avm_writedata[3]) tm_run <= 1'b0;
                    end
                    4'd2: begin
                        tm_period[15:0] <= avm_writedata;
                        tm_count <= {tm_period[63:16], avm_writedata};
                        tm_run <= 1'b0;
                    end
                    4'd3: begin
                        tm_period[31:16] <= avm_writedata;
                        tm_count <= {tm_period[63:32], avm_writedata, tm_period[15:0]};
                        tm_run <= 1'b0;
                    end
                    4'd4: begin
                        tm_period[47:32] <= avm_writedata;
                        tm_count <= {tm_period[63:48], avm_writedata, tm_period[31:0]};
                        tm_run <= 1'b0;
                    end
                    4'd5: begin
                        tm_period[63:48] <= avm_writedata;
                        tm_count <= {avm_writedata, tm_period[47:0]};
                        tm_run <= 1'b0;
                    end
                    4'd6, 4'd7, 4'd8, 4'd9: begin
                        tm_snap <= tm_count;
                        exp_snap.push_back(tm_count);
                    end
                    default: tm_to <= tm_to;
                endcase
            end
        end
    end

    // Bus and event monitor, sampled on the falling edge
    logic [19:0] obs_wr[$];
    logic [19:0] exp_wr[$];
    logic [63:0] snap_obs[$];
    int cyc = 0;
    int tick_seen = 0;
    int tick_cyc = -100;
    int irq_late = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (avm_chipselect && !avm_write_n) obs_wr.push_back({avm_address, avm_writedata});
            if (tick) begin
                tick_seen <= tick_seen + 1;
                tick_cyc  <= cyc;
            end
            if (timer_irq && cyc == tick_cyc + 1) irq_late <= irq_late + 1;
            if (cfg_ack) begin
                ack_cnt <= ack_cnt + 1;
                ack_cyc <= cyc;
            end
            if (snap_ack) snap_obs.push_back(snap_value);
        end
    end

    task automatic push_cfg_writes(input logic [63:0] p, input logic c);
        exp_wr.push_back(20'h1_0008);
        for (int h = 0; h < 4; h++) exp_wr.push_back({4'(2 + h), p[h*16 +: 16]});
        exp_wr.push_back({4'h1, 16'h0005 | {14'd0, c, 1'b0}});
        exp_wr.push_back(20'h0_0000);
    endtask

    task automatic run_cfg(input logic [63:0] p, input logic c, output int lat);
        @(posedge clk);
        #1;
        cfg_period = p;
        cfg_continuous = c;
        cfg_req = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cfg_ack) begin
                lat = k;
                break;
            end
        end
        cfg_req = 1'b0;
    endtask

    task automatic run_snap(output int lat);
        @(posedge clk);
        #1;
        snap_req = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (snap_ack) begin
                lat = k;
                break;
            end
        end
        snap_req = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        int s;
        s = tick_seen;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (tick_seen != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({cfg_ack, snap_ack, tick, busy, avm_chipselect} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 00000", {cfg_ack, snap_ack, tick, busy, avm_chipselect});
        end
        n_tests++;
        if (avm_write_n !== 1'b1 || avm_address !== 4'd0 || avm_writedata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got wn=%b a=%0d d=%h expected wn=1 a=0 d=0", avm_write_n, avm_address, avm_writedata);
        end
        n_tests++;
        if (snap_value !== 64'd0 || tick_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got snap=%h count=%0d expected 0 0", snap_value, tick_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_cfg_periodic();
        int lat, wb, t1;
        bit ok;
        logic [19:0] e;
        wb = obs_wr.size();
        push_cfg_writes(64'd99, 1'b1);
        run_cfg(64'd99, 1'b1, lat);
        @(posedge clk);
        #1;
        n_tests++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL cfg_latency: got %0d expected 7", lat);
        end
        n_tests++;
        if (obs_wr.size() - wb !== 7) begin
            n_fail++;
            $display("FAIL cfg_write_count: got %0d expected 7", obs_wr.size() - wb);
        end
        for (int i = 0; i < 7; i++) begin
            e = exp_wr.pop_front();
            if (wb + i < obs_wr.size()) begin
                n_tests++;
                if (obs_wr[wb + i] !== e) begin
                    n_fail++;
                    $display("FAIL cfg_write_%0d: got %h expected %h", i, obs_wr[wb + i], e);
                end
            end
        end
        wait_tick(300, ok);
        t1 = tick_cyc;
        if (ok) wait_tick(300, ok);
        n_tests++;
        if (!ok || tick_cyc - t1 !== 100) begin
            n_fail++;
            $display("FAIL tick_interval: got %0d (ok=%0d) expected 100", tick_cyc - t1, ok);
        end
    endtask

    task automatic test_tick_count();
        int s0, late0;
        bit ok;
        wait_tick(200, ok);
        s0 = tick_seen;
        late0 = irq_late;
        repeat (1000) @(posedge clk);
        #1;
        n_tests++;
        if (!ok || tick_seen - s0 !== 10) begin
            n_fail++;
            $display("FAIL ticks_in_1000: got %0d expected 10", tick_seen - s0);
        end
        n_tests++;
        if (tick_count !== TW'(to_events)) begin
            n_fail++;
            $display("FAIL tick_count_periodic: got %0d expected %0d", tick_count, TW'(to_events));
        end
        n_tests++;
        if (irq_late !== late0) begin
            n_fail++;
            $display("FAIL irq_cleared: got %0d late irqs expected 0", irq_late - late0);
        end
    endtask

    task automatic test_one_shot();
        int s0, lat;
        bit ok;
        wait_tick(200, ok);
        s0 = tick_seen;
        run_cfg(64'd9, 1'b0, lat);
        n_tests++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL oneshot_latency: got %0d expected 7", lat);
        end
        repeat (200) @(posedge clk);
        #1;
        n_tests++;
        if (tick_seen - s0 !== 1) begin
            n_fail++;
            $display("FAIL oneshot_ticks: got %0d expected 1", tick_seen - s0);
        end
        n_tests++;
        if (tick_count !== TW'(to_events)) begin
            n_fail++;
            $display("FAIL oneshot_count: got %0d expected %0d", tick_count, TW'(to_events));
        end
        repeat (200) @(posedge clk);
        #1;
        n_tests++;
        if (tick_seen - s0 !== 1) begin
            n_fail++;
            $display("FAIL oneshot_quiet: got %0d expected 1", tick_seen - s0);
        end
    endtask

    task automatic test_snapshot();
        int lat, wb, so;
        logic [63:0] e;
        logic [63:0] nominal;
        nominal = 64'hFFFF_FFFF_FFFF_FFCE;
        run_cfg(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat);
        repeat (50) @(posedge clk);
        wb = obs_wr.size();
        so = snap_obs.size();
        run_snap(lat);
        @(posedge clk);
        #1;
        n_tests++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL snap_latency: got %0d expected 6", lat);
        end
        n_tests++;
        if (obs_wr.size() - wb !== 1 || (obs_wr.size() > wb && obs_wr[wb] !== 20'h6_0000)) begin
            n_fail++;
            $display("FAIL snap_trigger: got %0d writes expected one write 6_0000", obs_wr.size() - wb);
        end
        n_tests++;
        if (exp_snap.size() !== 1 || snap_obs.size() - so !== 1) begin
            n_fail++;
            $display("FAIL snap_count: got %0d/%0d expected 1/1", exp_snap.size(), snap_obs.size() - so);
        end else begin
            e = exp_snap.pop_front();
            n_tests++;
            if (snap_obs[so] !== e) begin
                n_fail++;
                $display("FAIL snap_value: got %h expected %h", snap_obs[so], e);
            end
            n_tests++;
            if (e < nominal - 64'd4 || e > nominal + 64'd4) begin
                n_fail++;
                $display("FAIL snap_window: got %h expected %h +-4", e, nominal);
            end
            repeat (20) @(posedge clk);
            #1;
            n_tests++;
            if (snap_value !== e) begin
                n_fail++;
                $display("FAIL snap_hold: got %h expected %h", snap_value, e);
            end
        end
    endtask

    task automatic test_irq_vs_cfg();
        int lat, wb, s0;
        bit found;
        logic [19:0] e;
        run_cfg(64'd29, 1'b0, lat);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (tm_run && tm_count == 64'd0) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL irq_setup: got no timeout expected one within 100 clk");
        end
        s0 = tick_seen;
        wb = obs_wr.size();
        exp_wr.push_back(20'h0_0000);
        push_cfg_writes(64'd49, 1'b1);
        run_cfg(64'd49, 1'b1, lat);
        @(posedge clk);
        #1;
        n_tests++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL irq_first_latency: got %0d expected 10", lat);
        end
        n_tests++;
        if (tick_seen - s0 !== 1 || ack_cyc - tick_cyc !== 9) begin
            n_fail++;
            $display("FAIL irq_first_order: got ticks=%0d gap=%0d expected 1 and 9", tick_seen - s0, ack_cyc - tick_cyc);
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_wr.pop_front();
            n_tests++;
            if (wb + i >= obs_wr.size() || obs_wr[wb + i] !== e) begin
                n_fail++;
                $display("FAIL irq_cfg_write_%0d: got %h expected %h", i,
                         (wb + i < obs_wr.size()) ? obs_wr[wb + i] : 20'hxxxxx, e);
            end
        end
        n_tests++;
        if (tick_count !== TW'(to_events)) begin
            n_fail++;
            $display("FAIL irq_first_count: got %0d expected %0d", tick_count, TW'(to_events));
        end
    endtask

    task automatic test_reset_mid_cfg();
        int lat, wb, a0, base;
        bit ok;
        logic [19:0] e;
        a0 = ack_cnt;
        wb = obs_wr.size();
        @(posedge clk);
        #1;
        cfg_period = 64'h1234_5678_9ABC_DEF0;
        cfg_continuous = 1'b1;
        cfg_req = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({cfg_ack, snap_ack, tick, busy, avm_chipselect, avm_write_n} !== 6'b000001
            || avm_address !== 4'd0 || avm_writedata !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_bus: got %b a=%0d d=%h expected 000001 a=0 d=0",
                     {cfg_ack, snap_ack, tick, busy, avm_chipselect, avm_write_n}, avm_address, avm_writedata);
        end
        n_tests++;
        if (tick_count !== '0 || snap_value !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_values: got count=%0d snap=%h expected 0 0", tick_count, snap_value);
        end
        cfg_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ack_cnt !== a0 || obs_wr.size() - wb !== 3) begin
            n_fail++;
            $display("FAIL midreset_abandon: got acks=%0d writes=%0d expected 0 and 3", ack_cnt - a0, obs_wr.size() - wb);
        end
        base = tick_seen;
        wb = obs_wr.size();
        push_cfg_writes(64'd9, 1'b1);
        run_cfg(64'd9, 1'b1, lat);
        @(posedge clk);
        #1;
        n_tests++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL fresh_cfg_latency: got %0d expected 7", lat);
        end
        for (int i = 0; i < 7; i++) begin
            e = exp_wr.pop_front();
            n_tests++;
            if (wb + i >= obs_wr.size() || obs_wr[wb + i] !== e) begin
                n_fail++;
                $display("FAIL fresh_cfg_write_%0d: got %h expected %h", i,
                         (wb + i < obs_wr.size()) ? obs_wr[wb + i] : 20'hxxxxx, e);
            end
        end
        ok = 1'b1;
        while (ok && tick_seen - base < 255) wait_tick(40, ok);
        #1;
        n_tests++;
        if (!ok || tick_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL count_max: got %0d expected 255", tick_count);
        end
        wait_tick(40, ok);
        #1;
        n_tests++;
        if (!ok || tick_count !== 8'h00) begin
            n_fail++;
            $display("FAIL count_wrap: got %0d expected 0", tick_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cfg_periodic();
        test_tick_count();
        test_one_shot();
        test_snapshot();
        test_irq_vs_cfg();
        test_reset_mid_cfg();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
